// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the CDB writeback path.
// Source indices: 0 = alu0, 1 = alu1, 2 = mdu.
package uarch_pkg;

    localparam int unsigned CDB_PORTS_DEFAULT = 2;
    localparam int unsigned NUM_SRC           = 3;
    localparam int unsigned SRC_ALU0          = 0;
    localparam int unsigned SRC_ALU1          = 1;
    localparam int unsigned SRC_MDU           = 2;
    localparam int unsigned TAG_W             = 6;
    localparam int unsigned DATA_W            = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } writeback_packet_t;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic [1:0] wrap3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational 2-of-3 rotating pick; with fewer than 3 requesters every
// requester wins, otherwise the rotation (or forced mdu priority) decides.
module cdb_rr_pick
    import uarch_pkg::*;
(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [1:0]         i_rr_ptr,
    input  logic               i_force_mdu,
    output logic [NUM_SRC-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (&i_req) begin
            if (i_force_mdu) begin
                o_gnt[SRC_MDU] = 1'b1;
                // First ALU at or after rr_ptr; from mdu the rotation wraps to alu0.
                if (i_rr_ptr == 2'd1) begin
                    o_gnt[SRC_ALU1] = 1'b1;
                end else begin
                    o_gnt[SRC_ALU0] = 1'b1;
                end
            end else begin
                unique case (i_rr_ptr)
                    2'd0:    o_gnt = 3'b011;
                    2'd1:    o_gnt = 3'b110;
                    default: o_gnt = 3'b101;
                endcase
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two ALUs and one MDU share CDB_PORTS (=2) registered lanes.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
    import uarch_pkg::*;
#(
    parameter int unsigned CDB_PORTS    = CDB_PORTS_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_flush,
    input  writeback_packet_t [1:0]           i_alu_result,
    input  writeback_packet_t                 i_mdu_result,
    output logic [1:0]                        o_alu_cdb_gnt,
    output logic                              o_mdu_cdb_gnt,
    output writeback_packet_t [CDB_PORTS-1:0] o_cdb_out,
    output logic [31:0]                       o_stat_bcast_cnt,
    output logic [31:0]                       o_stat_deny_cnt
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    writeback_packet_t [CDB_PORTS-1:0] r_cdb_out;
    logic [1:0]                        r_rr_ptr;
    logic [3:0]                        r_starve_cnt;

    writeback_packet_t [NUM_SRC-1:0]   w_src_pkt;
    writeback_packet_t [CDB_PORTS-1:0] w_cdb_d;
    logic [NUM_SRC-1:0]                w_req;
    logic [NUM_SRC-1:0]                w_pick;
    logic [NUM_SRC-1:0]                w_gnt;
    logic [3:0]                        w_gnt_pad;
    logic                              w_force_mdu;
    logic                              w_deny;
    logic                              w_lane_used;
    logic [1:0]                        w_idx;
    logic [1:0]                        w_last;
    logic [1:0]                        w_rr_d;
    logic [3:0]                        w_starve_d;

    assign w_src_pkt   = {i_mdu_result, i_alu_result};
    assign w_req       = {i_mdu_result.valid, i_alu_result[1].valid, i_alu_result[0].valid};
    assign w_force_mdu = (r_starve_cnt == StarveMax);

    cdb_rr_pick u_pick (
        .i_req       (w_req),
        .i_rr_ptr    (r_rr_ptr),
        .i_force_mdu (w_force_mdu),
        .o_gnt       (w_pick)
    );

    // Grants are suppressed outright during reset or flush.
    assign w_gnt  = (i_rst_n && !i_flush) ? w_pick : '0;
    assign w_deny = (&w_req) && !i_flush;

    assign o_alu_cdb_gnt = w_gnt[1:0];
    assign o_mdu_cdb_gnt = w_gnt[SRC_MDU];

    // Last granted source walking the rotation order from rr_ptr.
    always_comb begin
        w_gnt_pad = {1'b0, w_gnt};
        w_idx     = r_rr_ptr;
        w_last    = r_rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_gnt_pad[w_idx]) begin
                w_last = w_idx;
            end
            w_idx = wrap3_inc(w_idx);
        end
    end

    always_comb begin
        w_rr_d     = r_rr_ptr;
        w_starve_d = '0;
        if (i_flush) begin
            w_rr_d     = '0;
            w_starve_d = '0;
        end else begin
            if (w_deny) begin
                w_rr_d = wrap3_inc(w_last);
            end
            if (w_req[SRC_MDU] && !w_gnt[SRC_MDU]) begin
                w_starve_d = (r_starve_cnt == StarveMax) ? StarveMax : r_starve_cnt + 4'd1;
            end
        end
    end

    // Lowest granted source index lands in lane 0.
    always_comb begin
        w_cdb_d     = '0;
        w_lane_used = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_gnt[s]) begin
                if (!w_lane_used) begin
                    w_cdb_d[0]  = w_src_pkt[s];
                    w_lane_used = 1'b1;
                end else begin
                    w_cdb_d[1] = w_src_pkt[s];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cdb_out    <= '0;
            r_rr_ptr     <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_cdb_out    <= w_cdb_d;
            r_rr_ptr     <= w_rr_d;
            r_starve_cnt <= w_starve_d;
        end
    end

    assign o_cdb_out = r_cdb_out;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] r_bcast_cnt;
    logic [31:0] r_deny_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcast_cnt <= '0;
            r_deny_cnt  <= '0;
        end else begin
            r_bcast_cnt <= r_bcast_cnt + {30'd0, popcnt3(w_gnt)};
            if (w_deny) begin
                r_deny_cnt <= r_deny_cnt + 32'd1;
            end
        end
    end

    assign o_stat_bcast_cnt = r_bcast_cnt;
    assign o_stat_deny_cnt  = r_deny_cnt;
`else
    assign o_stat_bcast_cnt = '0;
    assign o_stat_deny_cnt  = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: grants checked combinationally, broadcasts
// queued at drive time and compared after the following rising edge.
module tb_cdb_arbiter;
    import uarch_pkg::*;

    localparam int unsigned Limit = 1;

    typedef writeback_packet_t [1:0] lanes_t;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    writeback_packet_t [1:0] alu_res;
    writeback_packet_t       mdu_res;
    logic [1:0]              alu_gnt;
    logic                    mdu_gnt;
    lanes_t                  cdb_out;
    logic [31:0]             stat_bcast;
    logic [31:0]             stat_deny;

    int     n_checks;
    int     n_errors;
    int     m_rr;
    int     m_starve;
    int     m_bcast;
    int     m_deny;
    lanes_t exp_q[$];

    cdb_arbiter #(
        .CDB_PORTS    (2),
        .STARVE_LIMIT (Limit)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_alu_result     (alu_res),
        .i_mdu_result     (mdu_res),
        .o_alu_cdb_gnt    (alu_gnt),
        .o_mdu_cdb_gnt    (mdu_gnt),
        .o_cdb_out        (cdb_out),
        .o_stat_bcast_cnt (stat_bcast),
        .o_stat_deny_cnt  (stat_deny)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef CDB_ARB_STATS_EN
        check_eq("stat_bcast", 128'(stat_bcast), 128'(m_bcast));
        check_eq("stat_deny", 128'(stat_deny), 128'(m_deny));
`else
        check_eq("stat_bcast_off", 128'(stat_bcast), 128'd0);
        check_eq("stat_deny_off", 128'(stat_deny), 128'd0);
`endif
    endtask

    // Called at posedge+1; leaves the bench at the next posedge+1.
    task automatic step(input logic [2:0] v, input logic fl);
        writeback_packet_t src[3];
        logic [2:0]        eg;
        lanes_t            el;
        lanes_t            got;
        int                den;
        int                lane;
        bit                forced;
        for (int s = 0; s < 3; s++) begin
            src[s].valid = v[s];
            src[s].tag   = 6'($urandom);
            src[s].data  = $urandom;
        end
        alu_res[0] = src[0];
        alu_res[1] = src[1];
        mdu_res    = src[2];
        flush      = fl;
        #1;
        eg     = 3'b000;
        den    = 0;
        forced = (m_starve == Limit);
        if (!fl) begin
            if (v != 3'b111) begin
                eg = v;
            end else begin
                if (forced) den = (m_rr == 1) ? 0 : 1;
                else den = (m_rr + 2) % 3;
                eg      = 3'b111;
                eg[den] = 1'b0;
            end
        end
        check_eq("gnt", 128'({mdu_gnt, alu_gnt}), 128'(eg));
        el   = '0;
        lane = 0;
        for (int s = 0; s < 3; s++) begin
            if (eg[s]) begin
                el[lane] = src[s];
                lane++;
            end
        end
        exp_q.push_back(el);
        if (fl) begin
            m_rr     = 0;
            m_starve = 0;
        end else begin
            if (v == 3'b111) begin
                if (forced) m_rr = (m_rr == 2) ? 1 : 0;
                else m_rr = den;
                m_deny++;
            end
            if (v[2] && !eg[2]) m_starve = (m_starve == Limit) ? Limit : m_starve + 1;
            else m_starve = 0;
            m_bcast += int'(eg[0]) + int'(eg[1]) + int'(eg[2]);
        end
        @(posedge clk);
        #1;
        got = cdb_out;
        check_eq("cdb", 128'(got), 128'(exp_q.pop_front()));
        check_stats();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        alu_res = '0;
        mdu_res = '0;
        alu_res[0].valid = 1'b1;
        alu_res[1].valid = 1'b1;
        mdu_res.valid    = 1'b1;
        m_rr     = 0;
        m_starve = 0;
        m_bcast  = 0;
        m_deny   = 0;
        exp_q.delete();
        #2;
        check_eq("rst_cdb", 128'(cdb_out), 128'd0);
        check_eq("rst_gnt", 128'({mdu_gnt, alu_gnt}), 128'd0);
        @(posedge clk);
        #1;
        check_eq("rst_cdb_edge", 128'(cdb_out), 128'd0);
        check_stats();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // alu0 + mdu both granted, rr_ptr stays 0 so the next full cycle picks alu0/alu1.
        step(3'b101, 1'b0);
        step(3'b111, 1'b0);

        // Rotation from rr_ptr=0: {alu0,alu1}, {mdu,alu0}, {alu1,mdu}.
        do_reset();
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);

        // Flush with all valid, then rotation restarts from 0 with starve cleared.
        step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        step(3'b111, 1'b0);

        // Ten full-contention cycles from reset: 20 broadcasts, 10 denials.
        do_reset();
        for (int i = 0; i < 10; i++) step(3'b111, 1'b0);
`ifdef CDB_ARB_STATS_EN
        check_eq("stat_bcast10", 128'(stat_bcast), 128'd20);
        check_eq("stat_deny10", 128'(stat_deny), 128'd10);
`endif

        // Asynchronous reset between edges wipes a live broadcast.
        step(3'b001, 1'b0);
        check_eq("pre_async_valid", 128'(cdb_out[0].valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_cdb", 128'(cdb_out), 128'd0);
        do_reset();

        for (int i = 0; i < 60; i++) begin
            step(3'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter CDB_PORTS, default 2: number of CDB broadcast lanes; this revision supports only 2.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive denied cycles after which mdu gets forced priority; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  pipeline flush, synchronous, active-high.
REQ-006 alu_result  input  writeback_packet_t[1:0]  ALU results; request when .valid=1.
REQ-007 mdu_result  input  writeback_packet_t  MDU result; request when .valid=1.
REQ-008 alu_cdb_gnt  output  1[1:0]  per-ALU grant, combinational, same cycle as the request.
REQ-009 mdu_cdb_gnt  output  1  MDU grant, combinational.
REQ-010 cdb_out  output  writeback_packet_t[CDB_PORTS-1:0]  registered broadcast lanes.
REQ-011 stat_bcast_cnt  output  32  broadcast count (see Configuration).
REQ-012 stat_deny_cnt  output  32  denied-request cycle count (see Configuration).

Function
REQ-013 Sources are indexed 0=alu0, 1=alu1, 2=mdu; each cycle at most 2 requesting sources receive a grant.
REQ-014 With 2 or fewer requesters and flush=0, every requester is granted.
REQ-015 With 3 requesters: if the starve flag is set, mdu is granted plus the first ALU at or after rr_ptr; otherwise the 2 sources at rr_ptr, rr_ptr+1 (mod 3) are granted.
REQ-016 Grants never assert for a source whose .valid=0; grants are all 0 while flush=1.
REQ-017 Granted packets are registered into cdb_out on the next edge, lowest source index into lane 0; 1-cycle latency; unused lanes get .valid=0.
REQ-018 Ungranted sources hold their packet unchanged; the arbiter stores no pending packet.
REQ-019 rr_ptr (2 bits, values 0-2) advances to (last granted index + 1) mod 3 only in cycles where a request was denied; otherwise it holds.
REQ-020 starve_cnt (4 bits) increments when mdu requests and is denied, clears when mdu is granted or not requesting, and saturates at STARVE_LIMIT; starve flag = (starve_cnt == STARVE_LIMIT).
REQ-021 On flush, next edge: cdb_out[*].valid=0, starve_cnt=0, rr_ptr=0; a flush cycle produces no broadcast.

Reset
REQ-022 While rst=0: cdb_out all fields 0, rr_ptr=0, starve_cnt=0, stat counters 0; grants are 0 combinationally.
REQ-023 Reset asserted mid-operation discards any registered broadcast immediately (asynchronously).

Configuration
REQ-024 Macro CDB_ARB_STATS_EN defined: stat_bcast_cnt adds the number of valid lanes written each edge; stat_deny_cnt adds 1 each cycle with any denied request; both wrap at 2^32 and are not cleared by flush.
REQ-025 Macro CDB_ARB_STATS_EN undefined: the counters are not built and both stat outputs are tied to 0.

Structure
REQ-026 writeback_packet_t, the CDB_PORTS default and the source-index constants live in uarch_pkg.
REQ-027 The 3-way rotating 2-of-3 pick is a sub-module cdb_rr_pick (requests, rr_ptr, force_mdu in; grant vector out; purely combinational).

Verification
REQ-028 alu0 and mdu valid, alu1 idle -> both granted; next cycle cdb_out[0]=alu0 packet, cdb_out[1]=mdu packet; rr_ptr unchanged.
REQ-029 All 3 valid, rr_ptr=0, held for 3 cycles -> grants {alu0,alu1}, then {mdu,alu0}, then {alu1,mdu}.
REQ-030 All 3 valid for 5 cycles, STARVE_LIMIT=1, alu ordering forced to deny mdu -> mdu granted in the cycle after its first denial.
REQ-031 flush=1 while all 3 valid -> all grants 0; next cycle cdb_out valids=0, rr_ptr=0, starve_cnt=0.
REQ-032 rst driven low between edges while cdb_out[0].valid=1 -> cdb_out cleared before the next edge; with CDB_ARB_STATS_EN, 10 cycles of 3 requesters -> stat_bcast_cnt=20, stat_deny_cnt=10.
